multi_alarm_clock: RTL and testbench
====================================

MULTI_ALARM_CLOCK -- requirements
Module: multi_alarm_clock

Interface
REQ-001 Parameter: N_ALARMS, 4, number of independent alarm channels (1..8).
REQ-002 Parameter: TICK_DIV, 10, clk cycles per second tick (>=2).
REQ-003 Parameter: SNOOZE_MIN, 5, minute rollovers a snoozed channel waits before re-ringing (1..15).
REQ-004 Parameter: RING_TIMEOUT_MIN, 2, minute rollovers a ringing channel rings unattended before auto-stop (1..15).
REQ-005 clk  in  1  single system clock, all state on rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 H_in1  in  2, H_in0  in  4, M_in1  in  4, M_in0  in  4  BCD hour/minute load value.
REQ-008 LD_time  in  1  load clock time from H/M inputs.
REQ-009 LD_alarm  in  1  load alarm channel alarm_sel from H/M inputs.
REQ-010 alarm_sel  in  max(1,clog2(N_ALARMS))  channel index for LD_alarm.
REQ-011 AL_ON  in  N_ALARMS  per-channel enable.
REQ-012 STOP_al  in  1  stop all ringing/snoozed channels.
REQ-013 SNOOZE  in  1  snooze all ringing channels.
REQ-014 Alarm  out  N_ALARMS  per-channel ring indication, registered.
REQ-015 alarm_any  out  1  OR of Alarm, registered.
REQ-016 H_out1 2, H_out0 4, M_out1 4, M_out0 4, S_out1 4, S_out0 4  out  BCD current time, registered.

Function
REQ-017 Tick: prescaler counts 0..TICK_DIV-1; tick asserts one cycle at TICK_DIV-1.
REQ-018 On tick, time advances one second in BCD, 24-hour format: S 59->00 carries to M, M 59->00 carries to H, 23:59:59->00:00:00.
REQ-019 Minute rollover = tick on which S goes 59->00.
REQ-020 LD_time loads H:M, clears S to 00 and the prescaler; takes priority over a same-cycle tick.
REQ-021 Load values invalid (hour >23, H_in0/M_in0 >9, M_in1 >5) are ignored; all state unchanged.
REQ-022 LD_alarm writes channel alarm_sel's H:M; alarm_sel >= N_ALARMS ignored; the channel's FSM state is unaffected.
REQ-023 Trigger for channel i: AL_ON[i]=1, and new time has S=00 and H:M equal to alarm i, caused by either a minute rollover or LD_time.
REQ-024 Per-channel FSM states: IDLE, RINGING, SNOOZED.
REQ-025 IDLE->RINGING on trigger; Alarm[i] asserts the cycle after the trigger event.
REQ-026 RINGING->IDLE on STOP_al, or after RING_TIMEOUT_MIN minute rollovers without STOP_al or SNOOZE.
REQ-027 RINGING->SNOOZED on SNOOZE, loading the snooze counter with SNOOZE_MIN.
REQ-028 SNOOZED: counter decrements on each minute rollover; at 0 -> RINGING, with the ring-timeout counter restarted.
REQ-029 SNOOZED->IDLE on STOP_al; SNOOZED->RINGING on a fresh trigger.
REQ-030 STOP_al and SNOOZE in the same cycle: STOP_al wins.
REQ-031 AL_ON[i]=0 forces channel i to IDLE next cycle, in any state.
REQ-032 Alarm[i]=1 exactly in RINGING; alarm_any updates in the same cycle as Alarm.
REQ-033 Channels are independent; simultaneous triggers on several channels ring all of them.

Reset
REQ-034 reset low asynchronously clears: time 00:00:00, prescaler 0, all alarm registers 00:00, all FSMs IDLE, all counters 0, Alarm=0, alarm_any=0.
REQ-035 Reset asserted mid-ring or mid-snooze drops Alarm immediately, without waiting for a clock edge.
REQ-036 First tick after reset release occurs TICK_DIV cycles later.

Structure
REQ-037 Shared package alarm_clock_pkg holds the FSM state enum, BCD digit type, and default parameter constants.
REQ-038 Sub-module alarm_channel holds one channel's alarm register, FSM, snooze counter and ring-timeout counter; instantiated N_ALARMS times via generate.
REQ-039 Timekeeping, prescaler and load validation live in the top module.

Verification (TICK_DIV=10, N_ALARMS=4, SNOOZE_MIN=5, RING_TIMEOUT_MIN=2)
REQ-040 Set time 11:29, alarm 0 = 11:30, AL_ON=0001 -> Alarm=0001 one cycle after rollover to 11:30:00; STOP_al pulse -> Alarm=0000; no retrigger during 11:30.
REQ-041 Ringing channel 0, SNOOZE pulse -> Alarm[0]=0; re-asserts after 5 minute rollovers at 11:35:00; left unattended, clears at 11:37:00.
REQ-042 Set time 23:59 and run 60 ticks -> time 00:00:00; set invalid 24:00 or 12:6A -> time unchanged.
REQ-043 Alarms 1 and 3 both 07:00, AL_ON=1010, LD_time 07:00 -> Alarm=1010 next cycle; same-cycle STOP_al+SNOOZE -> all IDLE.
REQ-044 Reset pulsed low mid-ring -> Alarm=0 asynchronously; outputs 00:00:00; alarm registers 00:00.
REQ-045 Ringing channel 2, AL_ON[2]->0 -> Alarm[2]=0 next cycle; LD_alarm with alarm_sel=2 while ringing -> still ringing.

Source files
------------

// File: rtl/alarm_clock_pkg.sv
// Shared types and defaults for the multi-channel alarm clock.
// Holds the channel FSM encoding, the BCD digit type and the H:M validity check.
package alarm_clock_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RINGING = 2'd1,
        ST_SNOOZED = 2'd2
    } ch_state_e;

    typedef logic [3:0] bcd_t;

    localparam int DEF_N_ALARMS         = 4;
    localparam int DEF_TICK_DIV         = 10;
    localparam int DEF_SNOOZE_MIN       = 5;
    localparam int DEF_RING_TIMEOUT_MIN = 2;

    // True when h1h0:m1m0 is a legal 24-hour BCD time.
    function automatic logic hm_valid(input logic [1:0] h1, input bcd_t h0,
                                      input bcd_t m1, input bcd_t m0);
        return (h0 <= 4'd9) && (m1 <= 4'd5) && (m0 <= 4'd9) &&
               ((h1 < 2'd2) || ((h1 == 2'd2) && (h0 <= 4'd3)));
    endfunction

endpackage

// File: rtl/alarm_channel.sv
// One alarm channel: H:M alarm register, IDLE/RINGING/SNOOZED FSM, snooze and ring-timeout counters.
// ring_o is the registered state; ring_d_o is the next-state view used for the shared OR output.
module alarm_channel
    import alarm_clock_pkg::*;
#(
    parameter int SNOOZE_MIN       = DEF_SNOOZE_MIN,
    parameter int RING_TIMEOUT_MIN = DEF_RING_TIMEOUT_MIN
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       al_on_i,
    input  logic       ld_alarm_i,
    input  logic [1:0] ld_h1_i,
    input  bcd_t       ld_h0_i,
    input  bcd_t       ld_m1_i,
    input  bcd_t       ld_m0_i,
    input  logic       ev_i,
    input  logic       roll_i,
    input  logic [1:0] now_h1_i,
    input  bcd_t       now_h0_i,
    input  bcd_t       now_m1_i,
    input  bcd_t       now_m0_i,
    input  logic       stop_i,
    input  logic       snooze_i,
    output logic       ring_o,
    output logic       ring_d_o
);

    logic [1:0] al_h1_q;
    bcd_t       al_h0_q, al_m1_q, al_m0_q;
    ch_state_e  state_q, state_d;
    logic [3:0] snz_q, snz_d, tmo_q, tmo_d;
    logic       hit;

    // ev_i only fires when the new time has seconds at 00, so H:M equality is the whole trigger.
    assign hit = al_on_i && ev_i &&
                 ({now_h1_i, now_h0_i, now_m1_i, now_m0_i} == {al_h1_q, al_h0_q, al_m1_q, al_m0_q});

    always_comb begin
        state_d = state_q;
        snz_d   = snz_q;
        tmo_d   = tmo_q;
        if (!al_on_i) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (hit) begin
                        state_d = ST_RINGING;
                        tmo_d   = 4'(RING_TIMEOUT_MIN);
                    end
                end
                ST_RINGING: begin
                    if (stop_i) begin
                        state_d = ST_IDLE;
                    end else if (snooze_i) begin
                        state_d = ST_SNOOZED;
                        snz_d   = 4'(SNOOZE_MIN);
                    end else if (roll_i) begin
                        tmo_d = tmo_q - 4'd1;
                        if (tmo_q == 4'd1) state_d = ST_IDLE;
                    end
                end
                ST_SNOOZED: begin
                    if (stop_i) begin
                        state_d = ST_IDLE;
                    end else if (hit) begin
                        state_d = ST_RINGING;
                        tmo_d   = 4'(RING_TIMEOUT_MIN);
                    end else if (roll_i) begin
                        snz_d = snz_q - 4'd1;
                        if (snz_q == 4'd1) begin
                            state_d = ST_RINGING;
                            tmo_d   = 4'(RING_TIMEOUT_MIN);
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            snz_q   <= 4'd0;
            tmo_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            snz_q   <= snz_d;
            tmo_q   <= tmo_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            al_h1_q <= 2'd0;
            al_h0_q <= 4'd0;
            al_m1_q <= 4'd0;
            al_m0_q <= 4'd0;
        end else if (ld_alarm_i) begin
            al_h1_q <= ld_h1_i;
            al_h0_q <= ld_h0_i;
            al_m1_q <= ld_m1_i;
            al_m0_q <= ld_m0_i;
        end
    end

    assign ring_o   = (state_q == ST_RINGING);
    assign ring_d_o = (state_d == ST_RINGING);

endmodule

// File: rtl/multi_alarm_clock.sv
// 24-hour BCD clock with prescaler, validated time/alarm loading and N independent alarm channels.
// Time and Alarm outputs are registers; alarms ring the cycle after the minute rollover or load that matches.
module multi_alarm_clock
    import alarm_clock_pkg::*;
#(
    parameter int N_ALARMS         = DEF_N_ALARMS,
    parameter int TICK_DIV         = DEF_TICK_DIV,
    parameter int SNOOZE_MIN       = DEF_SNOOZE_MIN,
    parameter int RING_TIMEOUT_MIN = DEF_RING_TIMEOUT_MIN,
    localparam int SEL_W = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1,
    localparam int PW    = $clog2(TICK_DIV)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [1:0]          H_in1,
    input  logic [3:0]          H_in0,
    input  logic [3:0]          M_in1,
    input  logic [3:0]          M_in0,
    input  logic                LD_time,
    input  logic                LD_alarm,
    input  logic [SEL_W-1:0]    alarm_sel,
    input  logic [N_ALARMS-1:0] AL_ON,
    input  logic                STOP_al,
    input  logic                SNOOZE,
    output logic [N_ALARMS-1:0] Alarm,
    output logic                alarm_any,
    output logic [1:0]          H_out1,
    output logic [3:0]          H_out0,
    output logic [3:0]          M_out1,
    output logic [3:0]          M_out0,
    output logic [3:0]          S_out1,
    output logic [3:0]          S_out0
);

    logic [PW-1:0]       presc_q, presc_d;
    logic [1:0]          h1_q, h1_d;
    bcd_t                h0_q, h0_d, m1_q, m1_d, m0_q, m0_d, s1_q, s1_d, s0_q, s0_d;
    logic                tick, ld_ok, ld_time_ok, roll, ev;
    logic                alarm_any_q;
    logic [N_ALARMS-1:0] ring_d;

    assign tick       = (presc_q == PW'(TICK_DIV - 1));
    assign ld_ok      = hm_valid(H_in1, H_in0, M_in1, M_in0);
    assign ld_time_ok = LD_time && ld_ok;

    always_comb begin
        presc_d = tick ? '0 : presc_q + 1'b1;
        h1_d = h1_q; h0_d = h0_q; m1_d = m1_q; m0_d = m0_q; s1_d = s1_q; s0_d = s0_q;
        roll = 1'b0;
        ev   = 1'b0;
        if (ld_time_ok) begin
            h1_d = H_in1; h0_d = H_in0; m1_d = M_in1; m0_d = M_in0;
            s1_d = 4'd0;  s0_d = 4'd0;
            presc_d = '0;
            ev = 1'b1;
        end else if (tick) begin
            if (s0_q != 4'd9) begin
                s0_d = s0_q + 4'd1;
            end else begin
                s0_d = 4'd0;
                if (s1_q != 4'd5) begin
                    s1_d = s1_q + 4'd1;
                end else begin
                    s1_d = 4'd0;
                    roll = 1'b1;
                    ev   = 1'b1;
                    if (m0_q != 4'd9) begin
                        m0_d = m0_q + 4'd1;
                    end else begin
                        m0_d = 4'd0;
                        if (m1_q != 4'd5) begin
                            m1_d = m1_q + 4'd1;
                        end else begin
                            m1_d = 4'd0;
                            if ((h1_q == 2'd2) && (h0_q == 4'd3)) begin
                                h1_d = 2'd0;
                                h0_d = 4'd0;
                            end else if (h0_q == 4'd9) begin
                                h0_d = 4'd0;
                                h1_d = h1_q + 2'd1;
                            end else begin
                                h0_d = h0_q + 4'd1;
                            end
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc_q <= '0;
            h1_q <= 2'd0; h0_q <= 4'd0; m1_q <= 4'd0; m0_q <= 4'd0; s1_q <= 4'd0; s0_q <= 4'd0;
            alarm_any_q <= 1'b0;
        end else begin
            presc_q <= presc_d;
            h1_q <= h1_d; h0_q <= h0_d; m1_q <= m1_d; m0_q <= m0_d; s1_q <= s1_d; s0_q <= s0_d;
            alarm_any_q <= |ring_d;
        end
    end

    // Channels compare against the post-update time so a load-triggered match rings like a rollover.
    for (genvar i = 0; i < N_ALARMS; i++) begin : g_ch
        alarm_channel #(
            .SNOOZE_MIN       (SNOOZE_MIN),
            .RING_TIMEOUT_MIN (RING_TIMEOUT_MIN)
        ) u_ch (
            .clk        (clk),
            .rst_n      (reset),
            .al_on_i    (AL_ON[i]),
            .ld_alarm_i (LD_alarm && ld_ok && (alarm_sel == SEL_W'(i))),
            .ld_h1_i    (H_in1),
            .ld_h0_i    (H_in0),
            .ld_m1_i    (M_in1),
            .ld_m0_i    (M_in0),
            .ev_i       (ev),
            .roll_i     (roll),
            .now_h1_i   (h1_d),
            .now_h0_i   (h0_d),
            .now_m1_i   (m1_d),
            .now_m0_i   (m0_d),
            .stop_i     (STOP_al),
            .snooze_i   (SNOOZE),
            .ring_o     (Alarm[i]),
            .ring_d_o   (ring_d[i])
        );
    end

    assign alarm_any = alarm_any_q;
    assign H_out1 = h1_q;
    assign H_out0 = h0_q;
    assign M_out1 = m1_q;
    assign M_out0 = m0_q;
    assign S_out1 = s1_q;
    assign S_out0 = s0_q;

endmodule

// File: tb/tb_multi_alarm_clock.sv
// Directed and randomized checks of multi_alarm_clock against a seconds-of-day reference model.
module tb_multi_alarm_clock;

    localparam int TD = 10;
    localparam int SM = 5;
    localparam int RT = 2;

    logic       clk, reset;
    logic [1:0] H_in1;
    logic [3:0] H_in0, M_in1, M_in0;
    logic       LD_time, LD_alarm;
    logic [1:0] alarm_sel;
    logic [3:0] AL_ON;
    logic       STOP_al, SNOOZE;
    logic [3:0] Alarm;
    logic       alarm_any;
    logic [1:0] H_out1;
    logic [3:0] H_out0, M_out1, M_out0, S_out1, S_out0;

    multi_alarm_clock #(.N_ALARMS(4), .TICK_DIV(TD), .SNOOZE_MIN(SM), .RING_TIMEOUT_MIN(RT)) dut (
        .clk(clk), .reset(reset),
        .H_in1(H_in1), .H_in0(H_in0), .M_in1(M_in1), .M_in0(M_in0),
        .LD_time(LD_time), .LD_alarm(LD_alarm), .alarm_sel(alarm_sel), .AL_ON(AL_ON),
        .STOP_al(STOP_al), .SNOOZE(SNOOZE), .Alarm(Alarm), .alarm_any(alarm_any),
        .H_out1(H_out1), .H_out0(H_out0), .M_out1(M_out1), .M_out0(M_out0),
        .S_out1(S_out1), .S_out0(S_out0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    // Reference model: time as seconds of day, alarms as minutes of day, channel as mode 0/1/2.
    int presc, sod;
    int al_min[4];
    int mode[4], snz[4], tmo[4];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [31:0] bcd_of(input int s);
        int hh, mm, ss;
        hh = s / 3600; mm = (s / 60) % 60; ss = s % 60;
        return 32'(((hh / 10) << 20) | ((hh % 10) << 16) | ((mm / 10) << 12) |
                   ((mm % 10) << 8) | ((ss / 10) << 4) | (ss % 10));
    endfunction

    function automatic logic [3:0] exp_alarm();
        logic [3:0] a;
        for (int i = 0; i < 4; i++) a[i] = (mode[i] == 1);
        return a;
    endfunction

    task automatic model_reset();
        presc = 0; sod = 0;
        for (int i = 0; i < 4; i++) begin
            al_min[i] = 0; mode[i] = 0; snz[i] = 0; tmo[i] = 0;
        end
    endtask

    task automatic model_step();
        int  h, m;
        bit  ok, tick, ev, roll, hit;
        if (!reset) begin
            model_reset();
        end else begin
            h  = int'(H_in1) * 10 + int'(H_in0);
            m  = int'(M_in1) * 10 + int'(M_in0);
            ok = (H_in0 <= 9) && (M_in0 <= 9) && (M_in1 <= 5) && (h <= 23);
            tick = (presc == TD - 1);
            ev = 0; roll = 0;
            if (LD_time && ok) begin
                sod = (h * 60 + m) * 60; presc = 0; ev = 1;
            end else begin
                presc = tick ? 0 : presc + 1;
                if (tick) begin
                    roll = (sod % 60 == 59);
                    ev   = roll;
                    sod  = (sod + 1) % 86400;
                end
            end
            for (int i = 0; i < 4; i++) begin
                hit = AL_ON[i] && ev && (sod / 60 == al_min[i]);
                if (!AL_ON[i]) mode[i] = 0;
                else if (mode[i] == 0) begin
                    if (hit) begin mode[i] = 1; tmo[i] = RT; end
                end else if (mode[i] == 1) begin
                    if (STOP_al) mode[i] = 0;
                    else if (SNOOZE) begin mode[i] = 2; snz[i] = SM; end
                    else if (roll) begin
                        tmo[i]--;
                        if (tmo[i] == 0) mode[i] = 0;
                    end
                end else begin
                    if (STOP_al) mode[i] = 0;
                    else if (hit) begin mode[i] = 1; tmo[i] = RT; end
                    else if (roll) begin
                        snz[i]--;
                        if (snz[i] == 0) begin mode[i] = 1; tmo[i] = RT; end
                    end
                end
            end
            if (LD_alarm && ok && alarm_sel < 4) al_min[alarm_sel] = h * 60 + m;
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        chk("time", {10'd0, H_out1, H_out0, M_out1, M_out0, S_out1, S_out0}, bcd_of(sod));
        chk("alarm", {28'd0, Alarm}, {28'd0, exp_alarm()});
        chk("alarm_any", {31'd0, alarm_any}, {31'd0, |exp_alarm()});
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) cyc();
    endtask

    task automatic set_hm(input logic [1:0] h1, input logic [3:0] h0, input logic [3:0] m1, input logic [3:0] m0);
        H_in1 = h1; H_in0 = h0; M_in1 = m1; M_in0 = m0;
    endtask

    task automatic ld_time();
        LD_time = 1'b1; cyc(); LD_time = 1'b0;
    endtask

    task automatic ld_alarm(input logic [1:0] sel);
        alarm_sel = sel; LD_alarm = 1'b1; cyc(); LD_alarm = 1'b0;
    endtask

    function automatic logic [31:0] hms(input int h, input int m, input int s);
        return bcd_of((h * 60 + m) * 60 + s);
    endfunction

    logic [31:0] dut_time;
    assign dut_time = {10'd0, H_out1, H_out0, M_out1, M_out0, S_out1, S_out0};

    initial begin
        reset = 1'b0; LD_time = 1'b0; LD_alarm = 1'b0; alarm_sel = 2'd0; AL_ON = 4'd0;
        STOP_al = 1'b0; SNOOZE = 1'b0;
        set_hm(2'd0, 4'd0, 4'd0, 4'd0);
        model_reset();
        #2;
        chk("reset_time", dut_time, 32'd0);
        chk("reset_alarm", {28'd0, Alarm}, 32'd0);
        chk("reset_any", {31'd0, alarm_any}, 32'd0);
        run(2);
        reset = 1'b1;

        // first tick lands on the TICK_DIV-th edge after release
        run(TD - 1);
        chk("first_tick_pre", dut_time, 32'd0);
        cyc();
        chk("first_tick", dut_time, hms(0, 0, 1));

        // ring at 11:30, stop, then re-ring by load and exercise snooze/timeout
        AL_ON = 4'b0001;
        set_hm(2'd1, 4'd1, 4'd3, 4'd0); ld_alarm(2'd0);
        set_hm(2'd1, 4'd1, 4'd2, 4'd9); ld_time();
        run(599);
        chk("ring_pre", {28'd0, Alarm}, 32'd0);
        cyc();
        chk("ring_1130", {28'd0, Alarm}, 32'b0001);
        chk("time_1130", dut_time, hms(11, 30, 0));
        STOP_al = 1'b1; cyc(); STOP_al = 1'b0;
        chk("stop", {28'd0, Alarm}, 32'd0);
        run(300);
        set_hm(2'd1, 4'd1, 4'd3, 4'd0); ld_time();
        chk("ring_by_load", {28'd0, Alarm}, 32'b0001);
        SNOOZE = 1'b1; cyc(); SNOOZE = 1'b0;
        chk("snooze", {28'd0, Alarm}, 32'd0);
        run(2998);
        chk("snooze_hold", {28'd0, Alarm}, 32'd0);
        cyc();
        chk("rering_1135", {28'd0, Alarm}, 32'b0001);
        chk("time_1135", dut_time, hms(11, 35, 0));
        run(1199);
        chk("ring_1136", {28'd0, Alarm}, 32'b0001);
        cyc();
        chk("timeout_1137", {28'd0, Alarm}, 32'd0);
        chk("time_1137", dut_time, hms(11, 37, 0));

        // midnight wrap and rejected loads
        AL_ON = 4'd0;
        set_hm(2'd2, 4'd3, 4'd5, 4'd9); ld_time();
        run(600);
        chk("midnight", dut_time, 32'd0);
        set_hm(2'd2, 4'd4, 4'd0, 4'd0); ld_time();
        chk("bad_24h", dut_time, 32'd0);
        set_hm(2'd1, 4'd2, 4'd6, 4'hA); ld_time();
        chk("bad_12_6A", dut_time, 32'd0);

        // two channels ring together; STOP wins over SNOOZE
        set_hm(2'd0, 4'd7, 4'd0, 4'd0);
        ld_alarm(2'd1); ld_alarm(2'd3);
        AL_ON = 4'b1010;
        ld_time();
        chk("dual_ring", {28'd0, Alarm}, 32'b1010);
        chk("dual_any", {31'd0, alarm_any}, 32'd1);
        STOP_al = 1'b1; SNOOZE = 1'b1; cyc(); STOP_al = 1'b0; SNOOZE = 1'b0;
        chk("stop_wins", {28'd0, Alarm}, 32'd0);
        run(20);

        // alarm reload while ringing, then AL_ON drop
        set_hm(2'd0, 4'd8, 4'd0, 4'd0); ld_alarm(2'd2);
        AL_ON = 4'b0100;
        ld_time();
        chk("ch2_ring", {28'd0, Alarm}, 32'b0100);
        set_hm(2'd0, 4'd9, 4'd1, 4'd5); ld_alarm(2'd2);
        chk("ch2_reload", {28'd0, Alarm}, 32'b0100);
        AL_ON = 4'b0000; cyc();
        chk("ch2_off", {28'd0, Alarm}, 32'd0);

        // asynchronous reset while ringing
        AL_ON = 4'b0100; ld_time();
        chk("ch2_ring_0915", {28'd0, Alarm}, 32'b0100);
        #2 reset = 1'b0;
        #1 model_reset();
        chk("async_alarm", {28'd0, Alarm}, 32'd0);
        chk("async_any", {31'd0, alarm_any}, 32'd0);
        chk("async_time", dut_time, 32'd0);
        run(2);
        reset = 1'b1;
        AL_ON = 4'b1111;
        set_hm(2'd0, 4'd0, 4'd0, 4'd0); ld_time();
        chk("alarm_regs_cleared", {28'd0, Alarm}, 32'b1111);
        STOP_al = 1'b1; cyc(); STOP_al = 1'b0;

        // randomized traffic around 10:00..10:03
        set_hm(2'd1, 4'd0, 4'd0, 4'd0); ld_time();
        AL_ON = 4'($urandom);
        for (int k = 0; k < 3000; k++) begin
            LD_time  = ($urandom_range(0, 59) == 0);
            LD_alarm = ($urandom_range(0, 19) == 0);
            STOP_al  = ($urandom_range(0, 79) == 0);
            SNOOZE   = ($urandom_range(0, 39) == 0);
            alarm_sel = 2'($urandom_range(0, 3));
            set_hm(2'd1, 4'd0, 4'd0, 4'($urandom_range(0, 3)));
            if ($urandom_range(0, 7) == 0) M_in0 = 4'hC;
            if ($urandom_range(0, 199) == 0) AL_ON = 4'($urandom);
            cyc();
        end
        LD_time = 1'b0; LD_alarm = 1'b0; STOP_al = 1'b0; SNOOZE = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
